// File: rtl/operand_fetch_if.sv
// Bundle of decode, register-file, bypass and ID/EX signals around the operand fetch stage.
// The slave view belongs to the stage; the master view belongs to its surroundings.
interface operand_fetch_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr;
  logic                      in_use_rs1;
  logic                      in_use_rs2;
  logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
  logic                      in_is_load;
  logic [REG_WIDTH-1:0]      in_imm;
  logic [REG_WIDTH-1:0]      in_pc;
  logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr;
  logic [REG_WIDTH-1:0]      rf_rs1_data;
  logic [REG_WIDTH-1:0]      rf_rs2_data;
  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_is_load;
  logic [REG_WIDTH-1:0]      ex_result;
  logic                      wb_write_en;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic [REG_WIDTH-1:0]      wb_rd_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [REG_WIDTH-1:0]      out_rs1_data;
  logic [REG_WIDTH-1:0]      out_rs2_data;
  logic [REG_ADDR_WIDTH-1:0] out_rd_addr;
  logic                      out_is_load;
  logic [REG_WIDTH-1:0]      out_imm;
  logic [REG_WIDTH-1:0]      out_pc;
  logic [31:0]               stall_count;

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_use_rs1, in_use_rs2, in_rd_addr,
           in_is_load, in_imm, in_pc, rf_rs1_data, rf_rs2_data, ex_valid, ex_rd_addr,
           ex_is_load, ex_result, wb_write_en, wb_rd_addr, wb_rd_data, flush, out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_rs1_data, out_rs2_data,
           out_rd_addr, out_is_load, out_imm, out_pc, stall_count
  );

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_use_rs1, in_use_rs2, in_rd_addr,
           in_is_load, in_imm, in_pc, rf_rs1_data, rf_rs2_data, ex_valid, ex_rd_addr,
           ex_is_load, ex_result, wb_write_en, wb_rd_addr, wb_rd_data, flush, out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_rs1_data, out_rs2_data,
           out_rd_addr, out_is_load, out_imm, out_pc, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// RV32I decode-to-execute operand stage: register-file addressing, EX/WB bypass,
// load-use stall detection and a registered ID/EX output with valid/ready handshake.
module operand_fetch #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32
) (
  input logic           clk,
  input logic           rstn,
  operand_fetch_if.slave bus
);

  // EX beats WB because it holds the younger write to the same register.
  function automatic logic [REG_WIDTH-1:0] f_resolve(
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [REG_WIDTH-1:0]      rf_data,
    input logic                      ex_fwd,
    input logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input logic [REG_WIDTH-1:0]      ex_res,
    input logic                      wb_en,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic [REG_WIDTH-1:0]      wb_data
  );
    if (idx == '0)                     return '0;
    else if (ex_fwd && ex_rd == idx)   return ex_res;
    else if (wb_en && wb_rd == idx)    return wb_data;
    else                               return rf_data;
  endfunction

  logic                      r_out_valid;
  logic [REG_WIDTH-1:0]      r_out_rs1_data;
  logic [REG_WIDTH-1:0]      r_out_rs2_data;
  logic [REG_ADDR_WIDTH-1:0] r_out_rd_addr;
  logic                      r_out_is_load;
  logic [REG_WIDTH-1:0]      r_out_imm;
  logic [REG_WIDTH-1:0]      r_out_pc;
  logic [31:0]               r_stall_count;

  logic                 w_ex_fwd;
  logic [REG_WIDTH-1:0] w_rs1_val;
  logic [REG_WIDTH-1:0] w_rs2_val;
  logic                 w_rs1_hit;
  logic                 w_rs2_hit;
  logic                 w_hazard;
  logic                 w_in_ready;
  logic                 w_accept;

  assign bus.rf_rs1_addr = bus.in_rs1_addr;
  assign bus.rf_rs2_addr = bus.in_rs2_addr;

  // A load in EX has no data yet, so it must never be forwarded.
  assign w_ex_fwd  = bus.ex_valid && !bus.ex_is_load;
  assign w_rs1_val = f_resolve(bus.in_rs1_addr, bus.rf_rs1_data, w_ex_fwd, bus.ex_rd_addr,
                               bus.ex_result, bus.wb_write_en, bus.wb_rd_addr, bus.wb_rd_data);
  assign w_rs2_val = f_resolve(bus.in_rs2_addr, bus.rf_rs2_data, w_ex_fwd, bus.ex_rd_addr,
                               bus.ex_result, bus.wb_write_en, bus.wb_rd_addr, bus.wb_rd_data);

  assign w_rs1_hit  = bus.in_use_rs1 && (bus.in_rs1_addr == bus.ex_rd_addr);
  assign w_rs2_hit  = bus.in_use_rs2 && (bus.in_rs2_addr == bus.ex_rd_addr);
  assign w_hazard   = bus.in_valid && bus.ex_valid && bus.ex_is_load &&
                      (bus.ex_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);
  assign w_in_ready = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid    <= 1'b0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_rd_addr  <= '0;
      r_out_is_load  <= 1'b0;
      r_out_imm      <= '0;
      r_out_pc       <= '0;
      r_stall_count  <= '0;
    end else begin
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_out_rs1_data <= w_rs1_val;
        r_out_rs2_data <= w_rs2_val;
        r_out_rd_addr  <= bus.in_rd_addr;
        r_out_is_load  <= bus.in_is_load;
        r_out_imm      <= bus.in_imm;
        r_out_pc       <= bus.in_pc;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_hazard && !bus.flush && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rs1_data = r_out_rs1_data;
  assign bus.out_rs2_data = r_out_rs2_data;
  assign bus.out_rd_addr  = r_out_rd_addr;
  assign bus.out_is_load  = r_out_is_load;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_pc       = r_out_pc;
  assign bus.stall_count  = r_stall_count;

endmodule
